// File: rtl/lc3_pkg.sv
// Shared LC-3 widths and the register_dump state encoding.
package lc3_pkg;

   localparam int LC3_DATA_WIDTH     = 16;
   localparam int LC3_REG_ADDR_WIDTH = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_SEND_A   = 3'd2,
      ST_SEND_B   = 3'd3,
      ST_DONE     = 3'd4,
      ST_SEND_SUM = 3'd5
   } dump_state_t;

endpackage

// File: rtl/register_dump.sv
// Walks a register range two registers per fetch and streams each value over valid/ready.
// Optional trailing checksum word when REGISTER_DUMP_CHECKSUM_EN is defined.
module register_dump
   import lc3_pkg::*;
#(
   parameter int DATA_WIDTH = LC3_DATA_WIDTH,
   parameter int ADDR_WIDTH = LC3_REG_ADDR_WIDTH
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_first_reg,
   input  logic [ADDR_WIDTH-1:0] i_last_reg,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [ADDR_WIDTH-1:0] o_rf_addr_a,
   output logic [ADDR_WIDTH-1:0] o_rf_addr_b,
   input  logic [DATA_WIDTH-1:0] i_rf_data_a,
   input  logic [DATA_WIDTH-1:0] i_rf_data_b,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic [ADDR_WIDTH-1:0] o_out_addr,
   output logic                  o_out_last
);

   dump_state_t           r_state;
   dump_state_t           w_state_next;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr_b;
   logic [ADDR_WIDTH-1:0] r_end;
   logic [DATA_WIDTH-1:0] r_data_a;
   logic [DATA_WIDTH-1:0] r_data_b;
   logic                  w_a_is_end;
   logic                  w_b_is_end;
   logic                  w_valid;
   logic [DATA_WIDTH-1:0] w_data;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_last;
   dump_state_t           w_after_regs;

`ifdef REGISTER_DUMP_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_sum;
   assign w_after_regs = ST_SEND_SUM;
`else
   assign w_after_regs = ST_DONE;
`endif

   assign w_a_is_end = (r_ptr == r_end);
   assign w_b_is_end = (r_ptr_b == r_end);

   always_comb begin
      w_state_next = r_state;
      w_valid      = 1'b0;
      w_data       = '0;
      w_addr       = '0;
      w_last       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_state_next = ST_FETCH;
         end
         ST_FETCH: begin
            w_state_next = ST_SEND_A;
         end
         ST_SEND_A: begin
            w_valid = 1'b1;
            w_data  = r_data_a;
            w_addr  = r_ptr;
`ifndef REGISTER_DUMP_CHECKSUM_EN
            w_last  = w_a_is_end;
`endif
            if (i_out_ready) w_state_next = w_a_is_end ? w_after_regs : ST_SEND_B;
         end
         ST_SEND_B: begin
            w_valid = 1'b1;
            w_data  = r_data_b;
            w_addr  = r_ptr_b;
`ifndef REGISTER_DUMP_CHECKSUM_EN
            w_last  = w_b_is_end;
`endif
            if (i_out_ready) w_state_next = w_b_is_end ? w_after_regs : ST_FETCH;
         end
`ifdef REGISTER_DUMP_CHECKSUM_EN
         ST_SEND_SUM: begin
            w_valid = 1'b1;
            w_data  = r_sum;
            w_addr  = '1;
            w_last  = 1'b1;
            if (i_out_ready) w_state_next = ST_DONE;
         end
`endif
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Pointers double as the read addresses so the register file sees flop outputs.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_ptr_b  <= '0;
         r_end    <= '0;
         r_data_a <= '0;
         r_data_b <= '0;
`ifdef REGISTER_DUMP_CHECKSUM_EN
         r_sum    <= '0;
`endif
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_ptr   <= i_first_reg;
                  r_ptr_b <= i_first_reg + ADDR_WIDTH'(1);
                  r_end   <= i_last_reg;
`ifdef REGISTER_DUMP_CHECKSUM_EN
                  r_sum   <= '0;
`endif
               end
            end
            ST_FETCH: begin
               r_data_a <= i_rf_data_a;
               r_data_b <= i_rf_data_b;
            end
            ST_SEND_A: begin
`ifdef REGISTER_DUMP_CHECKSUM_EN
               if (i_out_ready) r_sum <= r_sum + r_data_a;
`endif
            end
            ST_SEND_B: begin
               if (i_out_ready) begin
`ifdef REGISTER_DUMP_CHECKSUM_EN
                  r_sum <= r_sum + r_data_b;
`endif
                  if (!w_b_is_end) begin
                     r_ptr   <= r_ptr + ADDR_WIDTH'(2);
                     r_ptr_b <= r_ptr_b + ADDR_WIDTH'(2);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_busy      = (r_state != ST_IDLE);
   assign o_done      = (r_state == ST_DONE);
   assign o_rf_addr_a = r_ptr;
   assign o_rf_addr_b = r_ptr_b;
   assign o_out_valid = w_valid;
   assign o_out_data  = w_data;
   assign o_out_addr  = w_addr;
   assign o_out_last  = w_last;

endmodule

// File: tb/tb_register_dump.sv
// Self-checking bench for register_dump: directed table, stall/reset sequences, randomized dumps.
module tb_register_dump;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  first_reg, last_reg;
   logic        busy, done;
   logic [3:0]  rf_addr_a, rf_addr_b;
   logic [15:0] rf_data_a, rf_data_b;
   logic        out_valid, out_ready, out_last;
   logic [15:0] out_data;
   logic [3:0]  out_addr;

   logic [15:0] rf [16];

   always #5 clk = ~clk;

   assign rf_data_a = rf[rf_addr_a];
   assign rf_data_b = rf[rf_addr_b];

   register_dump dut (
      .i_clock     (clk),
      .i_reset     (rst_n),
      .i_start     (start),
      .i_first_reg (first_reg),
      .i_last_reg  (last_reg),
      .o_busy      (busy),
      .o_done      (done),
      .o_rf_addr_a (rf_addr_a),
      .o_rf_addr_b (rf_addr_b),
      .i_rf_data_a (rf_data_a),
      .i_rf_data_b (rf_data_b),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_addr  (out_addr),
      .o_out_last  (out_last)
   );

`ifdef REGISTER_DUMP_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   typedef struct {
      logic [3:0]  a;
      logic [15:0] d;
      logic        l;
   } word_t;

   typedef struct {
      logic [3:0]  first;
      logic [3:0]  last;
      int          mode;
      int          exp_regs;
      logic [15:0] exp_first_data;
      logic [15:0] exp_last_data;
   } vec_t;

   word_t exp_q[$];
   int    n_regs;
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic preload_directed();
      for (int n = 0; n < 16; n++) rf[n] = 16'(16'h0101 * n);
   endtask

   // Reference: range length from modular distance, data from the register array, optional sum word.
   task automatic build_model(input logic [3:0] f, input logic [3:0] l);
      word_t w;
      int    sum;
      exp_q.delete();
      n_regs = ((int'(l) - int'(f) + 16) % 16) + 1;
      sum = 0;
      for (int i = 0; i < n_regs; i++) begin
         w.a = 4'((int'(f) + i) % 16);
         w.d = rf[w.a];
         w.l = (CS == 0) && (i == n_regs - 1);
         sum = sum + int'(w.d);
         exp_q.push_back(w);
      end
      if (CS != 0) begin
         w.a = 4'hF;
         w.d = 16'(sum % 65536);
         w.l = 1'b1;
         exp_q.push_back(w);
      end
   endtask

   task automatic do_dump(input logic [3:0] f, input logic [3:0] l, input int mode,
                          output int nwords, output logic [15:0] fd, output logic [15:0] ld);
      int    cyc, idx, pat, last_hs, exp_cycles;
      bit    held, done_seen, seen_valid, r;
      word_t prev;
      build_model(f, l);
      exp_cycles = n_regs + (n_regs + 1) / 2 + CS;
      idx = 0; pat = 0; held = 0; done_seen = 0; seen_valid = 0; last_hs = 0;
      fd = '0; ld = '0;
      prev.a = '0; prev.d = '0; prev.l = 1'b0;
      @(negedge clk);
      start = 1'b1; first_reg = f; last_reg = l; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; first_reg = 4'($urandom); last_reg = 4'($urandom);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("valid_in_fetch", 32'(out_valid), 32'd0);
      cyc = 1;
      while (!done_seen && cyc < 300) begin
         if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(prev.d));
            chk("hold_addr", 32'(out_addr), 32'(prev.a));
            chk("hold_last", 32'(out_last), 32'(prev.l));
         end
         if (out_valid && !seen_valid) begin
            seen_valid = 1;
            chk("first_valid_latency", 32'(cyc), 32'd2);
         end
         case (mode)
            0: r = 1'b1;
            1: r = (pat % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         out_ready = r;
         if (done) begin
            done_seen = 1;
            chk("done_word_count", 32'(idx), 32'(exp_q.size()));
            chk("done_latency", 32'(cyc - last_hs), 32'd1);
            chk("busy_during_done", 32'(busy), 32'd1);
         end else begin
            if (out_valid) begin
               pat++;
               if (r) begin
                  if (idx < exp_q.size()) begin
                     chk("word_addr", 32'(out_addr), 32'(exp_q[idx].a));
                     chk("word_data", 32'(out_data), 32'(exp_q[idx].d));
                     chk("word_last", 32'(out_last), 32'(exp_q[idx].l));
                     if (idx == 0) fd = out_data;
                     if (idx == n_regs - 1) ld = out_data;
                  end else begin
                     chk("extra_word", 32'(idx), 32'(exp_q.size() - 1));
                  end
                  idx++;
                  last_hs = cyc;
                  held = 0;
                  if (idx == exp_q.size() && mode == 0)
                     chk("throughput_cycles", 32'(cyc), 32'(exp_cycles));
               end else begin
                  held = 1;
                  prev.a = out_addr; prev.d = out_data; prev.l = out_last;
               end
            end
            @(negedge clk);
            cyc++;
         end
      end
      if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
      out_ready = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("valid_after_done", 32'(out_valid), 32'd0);
      nwords = idx;
   endtask

   vec_t        vecs[7];
   int          nw;
   logic [15:0] fd, ld;
   bit          found;

   initial begin
      vecs[0] = '{4'd0,  4'd7,  0, 8,  16'h0000, 16'h0707};
      vecs[1] = '{4'd3,  4'd3,  0, 1,  16'h0303, 16'h0303};
      vecs[2] = '{4'd14, 4'd1,  0, 4,  16'h0E0E, 16'h0101};
      vecs[3] = '{4'd0,  4'd3,  1, 4,  16'h0000, 16'h0303};
      vecs[4] = '{4'd15, 4'd0,  1, 2,  16'h0F0F, 16'h0000};
      vecs[5] = '{4'd9,  4'd9,  2, 1,  16'h0909, 16'h0909};
      vecs[6] = '{4'd0,  4'd15, 0, 16, 16'h0000, 16'h0F0F};

      preload_directed();
      rst_n = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_addr", 32'(out_addr), 32'd0);
      chk("rst_rf_a", 32'(rf_addr_a), 32'd0);
      chk("rst_rf_b", 32'(rf_addr_b), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_dump(vecs[i].first, vecs[i].last, vecs[i].mode, nw, fd, ld);
         $display("vec %0d range %0d..%0d mode %0d words %0d", i, vecs[i].first, vecs[i].last, vecs[i].mode, nw);
         chk("vec_word_count", 32'(nw), 32'(vecs[i].exp_regs + CS));
         chk("vec_first_data", 32'(fd), 32'(vecs[i].exp_first_data));
         chk("vec_last_data", 32'(ld), 32'(vecs[i].exp_last_data));
      end

`ifdef REGISTER_DUMP_CHECKSUM_EN
      build_model(4'd0, 4'd7);
      chk("checksum_model_value", 32'(exp_q[8].d), 32'h1C1C);
`endif

      // Reset while the B word of pair 4/5 is presented.
      @(negedge clk);
      start = 1'b1; first_reg = 4'd0; last_reg = 4'd7; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (out_valid && out_addr == 4'd5) begin
            found = 1;
            rst_n = 1'b0;
         end
         @(negedge clk);
      end
      chk("midreset_found_addr5", 32'(found), 32'd1);
      chk("midreset_valid", 32'(out_valid), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      $display("mid-dump reset at addr 5 applied %0d", found);
      rst_n = 1'b1; out_ready = 1'b0;
      do_dump(4'd0, 4'd1, 0, nw, fd, ld);
      chk("post_reset_words", 32'(nw), 32'(2 + CS));
      chk("post_reset_last", 32'(ld), 32'h0101);

      // Randomized contents, ranges and backpressure.
      for (int t = 0; t < 24; t++) begin
         logic [3:0] rf_first, rf_last;
         for (int n = 0; n < 16; n++) rf[n] = 16'($urandom);
         rf_first = 4'($urandom);
         rf_last  = 4'($urandom);
         do_dump(rf_first, rf_last, 2, nw, fd, ld);
         $display("rand %0d range %0d..%0d words %0d", t, rf_first, rf_last, nw);
         chk("rand_word_count", 32'(nw), 32'(exp_q.size()));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_dump.md
# register_dump

Sequenced reader for the LC-3 register file: on a start request it walks a contiguous register range through both read ports (two registers per fetch) and streams each value out over a valid/ready handshake. It sits between the register file read ports and the debug/host link (e.g. UART framer), so register state can be inspected without halting the datapath writer.

## Interface
- DATA_WIDTH, 16, register width
- ADDR_WIDTH, 4, register-file address width; ranges wrap modulo 2^ADDR_WIDTH

- clock  in  1  rising-edge clock, single domain
- reset  in  1  synchronous, active-low
- start  in  1  request a dump; sampled only in IDLE
- first_reg  in  ADDR_WIDTH  first register of range; latched on accepted start
- last_reg  in  ADDR_WIDTH  last register of range, inclusive; latched on accepted start
- busy  out  1  high from the cycle after accepted start until DONE exits
- done  out  1  one-cycle pulse after the final word handshakes
- rf_addr_a  out  ADDR_WIDTH  register-file read address A
- rf_addr_b  out  ADDR_WIDTH  register-file read address B
- rf_data_a  in  DATA_WIDTH  combinational read data for rf_addr_a
- rf_data_b  in  DATA_WIDTH  combinational read data for rf_addr_b
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  DATA_WIDTH  register value
- out_addr  out  ADDR_WIDTH  register index of out_data
- out_last  out  1  marks the final word of the dump

## Operation
- States: IDLE, FETCH, SEND_A, SEND_B, DONE.
- IDLE: start=1 latches first_reg into ptr and last_reg into end, then goes to FETCH. start is ignored in every other state.
- FETCH:
  - rf_addr_a=ptr, rf_addr_b=ptr+1 (mod 2^ADDR_WIDTH), both driven from registers.
  - Both read values and addresses are captured at the edge, then the block moves to SEND_A.
- SEND_A: presents word A.
  - On handshake with ptr==end, go to DONE.
  - Otherwise go to SEND_B.
- SEND_B: presents word B.
  - On handshake with ptr+1==end, go to DONE.
  - Otherwise ptr+=2 and go to FETCH.
- DONE: done=1 for one cycle, then IDLE.
- Handshake occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_addr and out_last hold stable.
  - out_valid never drops without a handshake.
- out_last=1 on the word whose address equals end. With CHECKSUM enabled, out_last is instead asserted on the checksum word (see Configuration).
- Range length = ((end - first) mod 2^ADDR_WIDTH) + 1.
  - first==end gives a single word; port B data is fetched and discarded.
  - first>end wraps, e.g. 14..1 gives 14, 15, 0, 1.
- Captured data reflects register contents at the FETCH edge. Writes landing after FETCH are not observed until the next dump.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, out_addr=0, rf_addr_a=0, rf_addr_b=0; state IDLE.
- Reset asserted mid-dump: at that edge the block returns to IDLE and out_valid falls with no further words. In-flight words are dropped.
- Latency: with start sampled at edge k, FETCH runs in cycle k+1 and out_valid=1 in cycle k+2.
- With out_ready held high, one word per cycle within a pair plus one FETCH bubble per pair. Eight registers take 12 cycles from FETCH to the last handshake.
- done pulses in the cycle after the last handshake. busy falls in the cycle after done.
- A new start is accepted no earlier than the cycle after done (the IDLE cycle).

## Configuration
- REGISTER_DUMP_CHECKSUM_EN defined:
  - After the last register word, the block emits one extra word (state SEND_SUM).
  - out_data = sum of all emitted register words mod 2^DATA_WIDTH.
  - out_addr = all ones.
  - out_last is asserted on this word only.
  - The accumulator clears on accepted start.
- Undefined: no SEND_SUM state or accumulator; out_last is on the final register word.

## Structure
- Shared package/header lc3_pkg:
  - LC3_DATA_WIDTH=16 and LC3_REG_ADDR_WIDTH=4 (parameter defaults);
  - the state encoding constants for IDLE/FETCH/SEND_A/SEND_B/DONE/SEND_SUM.
- Single module; no sub-module is warranted. The checksum accumulator and pair buffer stay inline.

## Test plan
All directed tests preload the register file with Rn = 0x0101*n for n=0..15.

- Reset, then start with range 0..7 and out_ready=1 → 8 words 0x0000..0x0707 at addresses 0..7; out_last on address 7; done one cycle after; busy low afterwards.
- Range 3..3 → single word 0x0303 at out_addr 3 with out_last=1, then done.
- Range 14..1 → words 0x0E0E, 0x0F0F, 0x0000, 0x0101 in that order (wrap-around).
- Range 0..3 with out_ready toggling 1,0,0,1,… → no word lost or duplicated; out_data held stable while stalled.
- Reset pulled low while SEND_B is presenting address 5 → out_valid=0 and busy=0 at the next cycle; a subsequent start 0..1 dumps cleanly.
- With REGISTER_DUMP_CHECKSUM_EN, range 0..7 → a ninth word 0x1C1C with out_addr 0xF and out_last=1 only on that word.
